// File: rtl/instr_class_monitor.sv
// -----------------------------------------------------------------------------
// instr_class_monitor
//   Commit-stage observer. Classifies up to NrCommitPorts retiring 32-bit
//   encodings per cycle into 8 classes, keeps a wrapping counter per class
//   with a sticky wrap flag, and pushes every committed encrypted memory op
//   (LENC/SENC) into a small trace FIFO drained by a debug/trace sink.
//   Observation only: nothing here can stall commit.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   enable_i           1 = count and trace commits
//   clear_i            synchronous clear of counters, wrap flags, drop count
//   commit_valid_i     per-port retire strobe
//   commit_instr_i     per-port retiring encoding
//   commit_pc_i        per-port retiring PC
//   cnt_sel_i          class index for counter readout
//   cnt_o              registered counter of class cnt_sel_i (pre-update value)
//   cnt_ovf_o          sticky per-class wrap flags
//   trace_valid_o      FIFO head valid
//   trace_ready_i      sink accepts head
//   trace_data_o       {is_store, pc, instr} of head entry
//   drop_cnt_o         saturating count of trace entries lost to a full FIFO
//
// Trace handshake: the head entry transfers on a cycle where trace_valid_o and
// trace_ready_i are both high; trace_data_o holds steady while valid && !ready;
// a push into an empty FIFO becomes visible on the following cycle.
// -----------------------------------------------------------------------------
module instr_class_monitor #(
  parameter int NrCommitPorts = 2,
  parameter int VLEN          = 64,
  parameter int CNT_W         = 32,
  parameter int DEPTH         = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  enable_i,
  input  logic                                  clear_i,
  input  logic [NrCommitPorts-1:0]              commit_valid_i,
  input  logic [NrCommitPorts-1:0][31:0]        commit_instr_i,
  input  logic [NrCommitPorts-1:0][VLEN-1:0]    commit_pc_i,
  input  logic [2:0]                            cnt_sel_i,
  output logic [CNT_W-1:0]                      cnt_o,
  output logic [7:0]                            cnt_ovf_o,
  output logic                                  trace_valid_o,
  input  logic                                  trace_ready_i,
  output logic [VLEN+32:0]                      trace_data_o,
  output logic [15:0]                           drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = VLEN + 33;

  localparam int CLS_LOAD   = 0;
  localparam int CLS_STORE  = 1;
  localparam int CLS_LENC   = 2;
  localparam int CLS_SENC   = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JUMP   = 5;
  localparam int CLS_SYSTEM = 6;
  localparam int CLS_OTHER  = 7;

  // One-hot-ish class mask: LENC/SENC also set LOAD/STORE.
  function automatic logic [7:0] classify(input logic [31:0] ins);
    logic [7:0] m;
    m = '0;
    if (ins[1:0] != 2'b11) begin
      m[CLS_OTHER] = 1'b1;
    end else begin
      case (ins[6:0])
        7'b0000011: begin
          m[CLS_LOAD] = 1'b1;
          m[CLS_LENC] = (ins[14:12] == 3'b111);
        end
        7'b0100011: begin
          m[CLS_STORE] = 1'b1;
          m[CLS_SENC]  = (ins[14:12] == 3'b111);
        end
        7'b1100011: m[CLS_BRANCH] = 1'b1;
        7'b1101111,
        7'b1100111: m[CLS_JUMP]   = 1'b1;
        7'b1110011: m[CLS_SYSTEM] = 1'b1;
        default:    m[CLS_OTHER]  = 1'b1;
      endcase
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [8];
  logic [7:0]       ovf_q;
  logic [15:0]      drop_q;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;

  // ---------------------------------------------------------------------------
  // Per-port decode
  // ---------------------------------------------------------------------------
  logic [7:0]          hit      [NrCommitPorts];
  logic                counting [NrCommitPorts];
  logic [EW-1:0]       entry    [NrCommitPorts];
  logic                push_en  [NrCommitPorts];
  logic [AW-1:0]       push_idx [NrCommitPorts];
  logic [CW-1:0]       inc      [8];
  logic [CNT_W:0]      sum      [8];
  logic                pop;
  logic [CW-1:0]       free_slots;
  logic [CW-1:0]       rank;
  logic [CW-1:0]       n_push;
  logic [CW-1:0]       n_drop;
  logic [16:0]         drop_sum;

  always_comb begin
    for (int p = 0; p < NrCommitPorts; p++) begin
      hit[p]      = classify(commit_instr_i[p]);
      // clear wins over same-cycle commits, for counters and trace alike
      counting[p] = commit_valid_i[p] && enable_i && !clear_i;
      entry[p]    = {hit[p][CLS_SENC], commit_pc_i[p], commit_instr_i[p]};
    end

    for (int c = 0; c < 8; c++) begin
      inc[c] = '0;
      for (int p = 0; p < NrCommitPorts; p++) begin
        inc[c] = inc[c] + CW'(counting[p] && hit[p][c]);
      end
      sum[c] = {1'b0, cnt_q[c]} + (CNT_W+1)'(inc[c]);
    end
  end

  // ---------------------------------------------------------------------------
  // Trace FIFO push arbitration: candidates take consecutive slots in port
  // order; a same-cycle pop frees one extra slot. Anything beyond the free
  // slots is dropped, which naturally drops the highest ports first.
  // ---------------------------------------------------------------------------
  assign pop        = trace_valid_o && trace_ready_i;
  assign free_slots = CW'(DEPTH) - count_q + CW'(pop);

  always_comb begin
    rank   = '0;
    n_push = '0;
    for (int p = 0; p < NrCommitPorts; p++) begin
      push_en[p]  = 1'b0;
      push_idx[p] = wr_ptr_q + rank[AW-1:0];
      if (counting[p] && (hit[p][CLS_LENC] || hit[p][CLS_SENC])) begin
        if (rank < free_slots) begin
          push_en[p] = 1'b1;
          n_push     = n_push + 1'b1;
        end
        rank = rank + 1'b1;
      end
    end
    n_drop   = rank - n_push;
    drop_sum = {1'b0, drop_q} + 17'(n_drop);
  end

  // ---------------------------------------------------------------------------
  // Counters, flags, readout, drop count, FIFO pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < 8; c++) cnt_q[c] <= '0;
      ovf_q    <= '0;
      drop_q   <= '0;
      cnt_o    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      cnt_o <= cnt_q[cnt_sel_i];
      if (clear_i) begin
        for (int c = 0; c < 8; c++) cnt_q[c] <= '0;
        ovf_q  <= '0;
        drop_q <= '0;
      end else begin
        for (int c = 0; c < 8; c++) begin
          cnt_q[c] <= sum[c][CNT_W-1:0];
          if (sum[c][CNT_W]) ovf_q[c] <= 1'b1;
        end
        drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      // FIFO contents and pointers are untouched by clear_i
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      wr_ptr_q <= wr_ptr_q + n_push[AW-1:0];
      count_q  <= count_q - CW'(pop) + n_push;
    end
  end

  // Storage array carries no reset; validity is tracked by count_q.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < NrCommitPorts; p++) begin
      if (push_en[p]) mem_q[push_idx[p]] <= entry[p];
    end
  end

  assign cnt_ovf_o     = ovf_q;
  assign drop_cnt_o    = drop_q;
  assign trace_valid_o = (count_q != '0);
  assign trace_data_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_class_monitor.sv
module tb_instr_class_monitor;

  localparam int NP    = 2;
  localparam int VLEN  = 64;
  localparam int CNT_W = 4;
  localparam int DEPTH = 8;
  localparam int EW    = VLEN + 33;
  localparam int MAXV  = (1 << CNT_W) - 1;

  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_LENC = 32'h0000F283;
  localparam logic [31:0] I_SENC = 32'h00B57023;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_ADD  = 32'h00B50533;
  localparam logic [31:0] I_CMP  = 32'h00004501;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic                        enable;
  logic                        clear;
  logic [NP-1:0]               commit_valid;
  logic [NP-1:0][31:0]         commit_instr;
  logic [NP-1:0][VLEN-1:0]     commit_pc;
  logic [2:0]                  cnt_sel;
  logic [CNT_W-1:0]            cnt_o;
  logic [7:0]                  cnt_ovf_o;
  logic                        trace_valid_o;
  logic                        trace_ready;
  logic [EW-1:0]               trace_data_o;
  logic [15:0]                 drop_cnt_o;

  instr_class_monitor #(
    .NrCommitPorts (NP),
    .VLEN          (VLEN),
    .CNT_W         (CNT_W),
    .DEPTH         (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .clear_i        (clear),
    .commit_valid_i (commit_valid),
    .commit_instr_i (commit_instr),
    .commit_pc_i    (commit_pc),
    .cnt_sel_i      (cnt_sel),
    .cnt_o          (cnt_o),
    .cnt_ovf_o      (cnt_ovf_o),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready),
    .trace_data_o   (trace_data_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  int            n_checks;
  int            n_errors;
  logic [EW-1:0] exp_q[$];
  int            model_cnt[8];
  logic [7:0]    model_ovf;
  int            model_drop;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Class membership from the opcode table; LENC/SENC also belong to LOAD/STORE.
  function automatic logic [7:0] ref_classes(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [7:0] m;
    op = ins[6:0];
    f3 = ins[14:12];
    m  = '0;
    if (ins[1:0] != 2'b11)                 m[7] = 1'b1;
    else if (op == 7'h03) begin            m[0] = 1'b1; if (f3 == 3'd7) m[2] = 1'b1; end
    else if (op == 7'h23) begin            m[1] = 1'b1; if (f3 == 3'd7) m[3] = 1'b1; end
    else if (op == 7'h63)                  m[4] = 1'b1;
    else if (op == 7'h6F || op == 7'h67)   m[5] = 1'b1;
    else if (op == 7'h73)                  m[6] = 1'b1;
    else                                   m[7] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 8; c++) model_cnt[c] = 0;
    model_ovf  = '0;
    model_drop = 0;
    exp_q.delete();
  endtask

  // One clock: inputs already driven just after a falling edge.
  task automatic cycle();
    logic [CNT_W-1:0] exp_cnt;
    logic [7:0]       m;
    check("trace_valid", 128'(trace_valid_o), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("trace_data", 128'(trace_data_o), 128'(exp_q[0]));
    check("cnt_ovf", 128'(cnt_ovf_o), 128'(model_ovf));
    check("drop_cnt", 128'(drop_cnt_o), 128'(model_drop));

    exp_cnt = CNT_W'(model_cnt[cnt_sel]);
    if (trace_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (clear) begin
      for (int c = 0; c < 8; c++) model_cnt[c] = 0;
      model_ovf  = '0;
      model_drop = 0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (commit_valid[p] && enable) begin
          m = ref_classes(commit_instr[p]);
          for (int c = 0; c < 8; c++) begin
            if (m[c]) begin
              if (model_cnt[c] == MAXV) begin
                model_cnt[c] = 0;
                model_ovf[c] = 1'b1;
              end else begin
                model_cnt[c]++;
              end
            end
          end
          if (m[2] || m[3]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m[3], commit_pc[p], commit_instr[p]});
            else if (model_drop < 65535) model_drop++;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("cnt_o", 128'(cnt_o), 128'(exp_cnt));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    commit_valid = '0;
    commit_instr = '0;
    commit_pc    = '0;
    clear        = 1'b0;
  endtask

  task automatic drive(input logic [NP-1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    commit_valid    = v;
    commit_instr[0] = i0;
    commit_instr[1] = i1;
    commit_pc[0]    = {$urandom, $urandom};
    commit_pc[1]    = {$urandom, $urandom};
  endtask

  task automatic readout();
    idle_inputs();
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s);
      cycle();
    end
  endtask

  task automatic drain();
    idle_inputs();
    trace_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) cycle();
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] ins;
    ops = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h73, 7'h33, 7'h13, 7'h37};
    ins = $urandom;
    ins[6:0] = ops[$urandom_range(0, 8)];
    if ($urandom_range(0, 1) == 1) ins[14:12] = 3'b111;
    if ($urandom_range(0, 7) == 0) ins[1:0] = 2'($urandom_range(0, 2));
    return ins;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n       = 1'b0;
    enable      = 1'b1;
    trace_ready = 1'b0;
    cnt_sel     = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_cnt_o", 128'(cnt_o), 128'(0));
    check("rst_ovf", 128'(cnt_ovf_o), 128'(0));
    check("rst_valid", 128'(trace_valid_o), 128'(0));
    check("rst_drop", 128'(drop_cnt_o), 128'(0));
    rst_n = 1'b1;

    // all classes read zero after reset
    readout();

    // LW + LENC in one cycle
    drive(2'b11, I_LW, I_LENC);
    cycle();
    readout();
    drain();

    // BRANCH wrap: 15 single BEQs then a dual BEQ
    do_clear();
    for (int k = 0; k < 15; k++) begin
      drive(2'b01, I_BEQ, I_ADD);
      cycle();
    end
    drive(2'b11, I_BEQ, I_BEQ);
    cycle();
    readout();
    check("branch_wrapped", 128'(cnt_ovf_o[4]), 128'(1));

    // FIFO fill to 7, then overflow by one
    do_clear();
    trace_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, I_SENC, I_SENC);
      cycle();
    end
    drive(2'b01, I_SENC, I_ADD);
    cycle();
    drive(2'b11, I_SENC, I_SENC);
    cycle();
    idle_inputs();
    cycle();
    check("drop_one", 128'(drop_cnt_o), 128'(1));
    // pop once back to 7 entries, then two SENCs with a concurrent pop
    trace_ready = 1'b1;
    cycle();
    drive(2'b11, I_SENC, I_SENC);
    cycle();
    idle_inputs();
    trace_ready = 1'b0;
    cycle();
    check("drop_still_one", 128'(drop_cnt_o), 128'(1));
    drain();

    // clear with a concurrent ADD, FIFO holds an entry across it
    trace_ready = 1'b0;
    drive(2'b01, I_LENC, I_ADD);
    cycle();
    drive(2'b11, I_ADD, I_ADD);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    readout();
    drain();

    // enable low: nothing counted or traced; compressed goes to OTHER
    enable = 1'b0;
    drive(2'b11, I_LENC, I_LENC);
    cycle();
    enable = 1'b1;
    drive(2'b01, I_CMP, I_ADD);
    cycle();
    readout();

    // randomized traffic with a mid-run asynchronous reset
    for (int k = 0; k < 2000; k++) begin
      commit_valid    = NP'($urandom);
      commit_instr[0] = rand_instr();
      commit_instr[1] = rand_instr();
      commit_pc[0]    = {$urandom, $urandom};
      commit_pc[1]    = {$urandom, $urandom};
      enable          = ($urandom_range(0, 7) != 0);
      clear           = ($urandom_range(0, 63) == 0);
      trace_ready     = ($urandom_range(0, 3) == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
      cnt_sel         = 3'($urandom_range(0, 7));
      cycle();
      if (k == 1000) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_cnt_o", 128'(cnt_o), 128'(0));
        check("async_ovf", 128'(cnt_ovf_o), 128'(0));
        check("async_valid", 128'(trace_valid_o), 128'(0));
        check("async_drop", 128'(drop_cnt_o), 128'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    idle_inputs();
    enable = 1'b1;
    readout();
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
